// File: rtl/dma_ctrl.sv
// Byte DMA engine: copies len bytes src->dst as READ/WRITE pairs (2*len+1 cycles to done); optional DMA_FILL_EN
// adds a pattern-fill mode (len+1 cycles). No backpressure: the ram is assumed to respond every cycle.
`ifndef AddrBus
`define AddrBus [7:0]
`endif
`ifndef DataBus
`define DataBus [7:0]
`endif
`ifndef ENABLE_
`define ENABLE_ 1'b0
`endif
`ifndef DISABLE_
`define DISABLE_ 1'b1
`endif

module dma_ctrl (
    input  logic          clk,
    input  logic          reset_,
    input  logic          start,
    input  logic `AddrBus src,
    input  logic `AddrBus dst,
    input  logic `AddrBus len,
    input  logic          fill,
    input  logic `DataBus pattern,
    output logic          busy,
    output logic          done,
    output logic `AddrBus addr,
    output logic `DataBus d_out,
    input  logic `DataBus d_in,
    output logic          rd_,
    output logic          wr_
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic `AddrBus r_src;
    logic `AddrBus r_dst;
    logic `AddrBus r_count;
    logic `AddrBus r_i;
    logic `DataBus r_buf;
    logic          w_fill_sel;
    logic          w_fill_mode;
    logic `DataBus w_wdat;

`ifdef DMA_FILL_EN
    logic          r_fill;
    logic `DataBus r_pattern;

    assign w_fill_sel  = fill;
    assign w_fill_mode = r_fill;
    assign w_wdat      = r_fill ? r_pattern : r_buf;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_fill    <= 1'b0;
            r_pattern <= '0;
        end else if (r_state == S_IDLE && start && len != '0) begin
            r_fill    <= fill;
            r_pattern <= pattern;
        end
    end
`else
    // Fill mode compiled out: fill/pattern are deliberately ignored.
    logic w_unused_fill;
    assign w_unused_fill = ^{fill, pattern};
    assign w_fill_sel    = 1'b0;
    assign w_fill_mode   = 1'b0;
    assign w_wdat        = r_buf;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        addr   = '0;
        d_out  = '0;
        rd_    = `DISABLE_;
        wr_    = `DISABLE_;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = w_fill_sel ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                busy   = 1'b1;
                rd_    = `ENABLE_;
                addr   = r_src + r_i;
                w_next = S_WRITE;
            end
            S_WRITE: begin
                busy  = 1'b1;
                wr_   = `ENABLE_;
                addr  = r_dst + r_i;
                d_out = w_wdat;
                if (r_count == 8'd1) begin
                    w_next = S_DONE;
                end else begin
                    w_next = w_fill_mode ? S_WRITE : S_READ;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operands are only loaded in IDLE, so a start pulse mid-transfer cannot disturb them.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_count <= '0;
            r_i     <= '0;
            r_buf   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && len != '0) begin
                        r_src   <= src;
                        r_dst   <= dst;
                        r_count <= len;
                        r_i     <= '0;
                    end
                end
                S_READ: begin
                    r_buf <= d_in;
                end
                S_WRITE: begin
                    r_count <= r_count - 8'd1;
                    r_i     <= r_i + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl with a behavioural 256-byte ram attached.
module tb_dma_ctrl;

    logic       clk = 1'b0;
    logic       reset_;
    logic       start;
    logic [7:0] src, dst, len;
    logic       fill;
    logic [7:0] pattern;
    logic       busy, done;
    logic [7:0] addr, d_out, d_in;
    logic       rd_, wr_;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:255];
    logic [7:0] rq[$];
    logic [7:0] wq[$];
    logic       both_low = 1'b0;

    always #5 clk = ~clk;

    dma_ctrl dut (
        .clk     (clk),
        .reset_  (reset_),
        .start   (start),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .fill    (fill),
        .pattern (pattern),
        .busy    (busy),
        .done    (done),
        .addr    (addr),
        .d_out   (d_out),
        .d_in    (d_in),
        .rd_     (rd_),
        .wr_     (wr_)
    );

    always @(posedge clk) begin
        if (wr_ === 1'b0) mem[addr] <= d_out;
        if (rd_ === 1'b0 && wr_ === 1'b0) both_low <= 1'b1;
    end
    assign d_in = mem[addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // dc = edges from the start-accepting edge to the edge that samples done high (0 on timeout).
    task automatic run(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                       input logic f, input logic [7:0] p, input bit glitch,
                       output int dc, output int bz, output int nr, output int nw,
                       output bit done_one);
        rq.delete();
        wq.delete();
        src = s; dst = d; len = l; fill = f; pattern = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dc = 0; bz = 0; nr = 0; nw = 0; done_one = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            if (glitch) begin
                if (k == 3) begin
                    start = 1'b1; src = s + 8'h40; dst = d + 8'h40; len = 8'd1;
                end else begin
                    start = 1'b0;
                end
            end
            if (busy) bz++;
            if (!rd_) begin nr++; rq.push_back(addr); end
            if (!wr_) begin nw++; wq.push_back(addr); end
            if (done) begin
                dc = k;
                @(posedge clk); #1;
                done_one = !done && !busy;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int  dc, bz, nr, nw;
        bit  d1;
        reset_ = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0; fill = 1'b0; pattern = '0;
        for (int a = 0; a < 256; a++) mem[a] <= 8'h00;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd", rd_, 1);
        chk("rst_wr", wr_, 1);
        chk("rst_addr", addr, 0);
        chk("rst_dout", d_out, 0);
        @(posedge clk); #1 reset_ = 1'b1;
        @(posedge clk); #1;

        // basic 4-byte copy
        mem[8'h10] <= 8'h41; mem[8'h11] <= 8'h42; mem[8'h12] <= 8'h43; mem[8'h13] <= 8'h44;
        #1;
        run(8'h10, 8'h20, 8'd4, 1'b0, 8'h00, 1'b0, dc, bz, nr, nw, d1);
        chk("cp_done_lat", dc, 9);
        chk("cp_busy_cyc", bz, 8);
        chk("cp_nrd", nr, 4);
        chk("cp_nwr", nw, 4);
        chk("cp_done_pulse", d1, 1);
        chk("cp_rd0", rq[0], 8'h10);
        chk("cp_wr3", wq[3], 8'h23);
        chk("cp_m20", mem[8'h20], 8'h41);
        chk("cp_m21", mem[8'h21], 8'h42);
        chk("cp_m22", mem[8'h22], 8'h43);
        chk("cp_m23", mem[8'h23], 8'h44);

        // source address wraps FF -> 00
        mem[8'hFE] <= 8'hAA; mem[8'hFF] <= 8'hBB; mem[8'h00] <= 8'hCC;
        #1;
        run(8'hFE, 8'h02, 8'd3, 1'b0, 8'h00, 1'b0, dc, bz, nr, nw, d1);
        chk("wrap_lat", dc, 7);
        chk("wrap_rd1", rq[1], 8'hFF);
        chk("wrap_rd2", rq[2], 8'h00);
        chk("wrap_m02", mem[8'h02], 8'hAA);
        chk("wrap_m03", mem[8'h03], 8'hBB);
        chk("wrap_m04", mem[8'h04], 8'hCC);

        // zero length
        run(8'h10, 8'h60, 8'd0, 1'b0, 8'h00, 1'b0, dc, bz, nr, nw, d1);
        chk("z_lat", dc, 1);
        chk("z_busy", bz, 0);
        chk("z_nrd", nr, 0);
        chk("z_nwr", nw, 0);
        chk("z_done_pulse", d1, 1);

        // start pulsed mid-transfer with different operands
        mem[8'h50] <= 8'h11; mem[8'h51] <= 8'h22; mem[8'h52] <= 8'h33; mem[8'h53] <= 8'h44;
        mem[8'h90] <= 8'h99; mem[8'hA0] <= 8'h00;
        #1;
        run(8'h50, 8'h60, 8'd4, 1'b0, 8'h00, 1'b1, dc, bz, nr, nw, d1);
        chk("gl_lat", dc, 9);
        chk("gl_nwr", nw, 4);
        chk("gl_m60", mem[8'h60], 8'h11);
        chk("gl_m63", mem[8'h63], 8'h44);
        chk("gl_mA0", mem[8'hA0], 8'h00);

        // reset during the third WRITE of an 8-byte copy
        for (int a = 0; a < 8; a++) begin
            mem[8'h70 + a[7:0]] <= 8'h01 + a[7:0];
            mem[8'h80 + a[7:0]] <= 8'hEE;
        end
        #1;
        src = 8'h70; dst = 8'h80; len = 8'd8; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        nw = 0;
        for (int k = 0; k < 50; k++) begin
            if (!wr_) nw++;
            if (nw == 3) break;
            @(posedge clk); #1;
        end
        chk("rs_reach_w3", nw, 3);
        #2 reset_ = 1'b0;
        #1;
        chk("rs_rd", rd_, 1);
        chk("rs_wr", wr_, 1);
        chk("rs_busy", busy, 0);
        chk("rs_addr", addr, 0);
        @(posedge clk); #1;
        chk("rs_nodone", done, 0);
        reset_ = 1'b1;
        @(posedge clk); #1;
        chk("rs_nodone2", done, 0);
        chk("rs_m80", mem[8'h80], 8'h01);
        chk("rs_m81", mem[8'h81], 8'h02);
        chk("rs_m82", mem[8'h82], 8'hEE);
        run(8'h70, 8'h90, 8'd2, 1'b0, 8'h00, 1'b0, dc, bz, nr, nw, d1);
        chk("rs_next_lat", dc, 5);
        chk("rs_next_m90", mem[8'h90], 8'h01);
        chk("rs_next_m91", mem[8'h91], 8'h02);

        // overlapping ranges copy in ascending order
        mem[8'hB0] <= 8'h01; mem[8'hB1] <= 8'h02; mem[8'hB2] <= 8'h03;
        #1;
        run(8'hB0, 8'hB1, 8'd2, 1'b0, 8'h00, 1'b0, dc, bz, nr, nw, d1);
        chk("ov_mB1", mem[8'hB1], 8'h01);
        chk("ov_mB2", mem[8'hB2], 8'h01);

        // fill request: pattern fill with the macro, plain copy without it
        for (int a = 0; a < 5; a++) begin
            mem[8'h30 + a[7:0]] <= 8'h00;
            mem[8'h40 + a[7:0]] <= 8'hC0 + a[7:0];
        end
        #1;
        run(8'h40, 8'h30, 8'd5, 1'b1, 8'h5A, 1'b0, dc, bz, nr, nw, d1);
`ifdef DMA_FILL_EN
        chk("fill_lat", dc, 6);
        chk("fill_nrd", nr, 0);
        chk("fill_m30", mem[8'h30], 8'h5A);
        chk("fill_m34", mem[8'h34], 8'h5A);
`else
        chk("nofill_lat", dc, 11);
        chk("nofill_nrd", nr, 5);
        chk("nofill_m30", mem[8'h30], 8'hC0);
        chk("nofill_m34", mem[8'h34], 8'hC4);
`endif
        chk("fill_nwr", nw, 5);
        chk("never_both_low", both_low, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
